dm_arbiter: RTL and testbench
=============================

# dm_arbiter

Two-requester arbiter and sequencer for the single-port data memory (DM). It sits between the CPU MEM stage and the DM macro, and shares the DM with a DMA engine. Arbitration is round-robin, with a bounded DMA burst lock. The block returns read data one cycle after issue and drives a stall to the pipeline whenever the CPU is refused.

## Interface
Parameters:
- ADDR_W, 14, DM word-address width.
- MAX_BURST, 8, maximum DMA beats under one lock (≥1).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset; asynchronous, active-high.
- cpu_req  in  1  CPU requests one DM access this cycle.
- cpu_web  in  4  CPU byte write-enables, active-low; 4'b1111 = read.
- cpu_addr  in  ADDR_W  CPU word address.
- cpu_wdata  in  32  CPU write data, already lane-aligned.
- cpu_gnt  out  1  CPU access issued to DM this cycle.
- cpu_rvalid  out  1  CPU read data valid (cycle after granted read).
- cpu_rdata  out  32  CPU read data.
- cpu_stall  out  1  cpu_req & ~cpu_gnt.
- dma_req  in  1  DMA requests one beat this cycle.
- dma_web  in  4  DMA byte write-enables, active-low.
- dma_addr  in  ADDR_W  DMA word address.
- dma_wdata  in  32  DMA write data.
- dma_last  in  1  current DMA beat is last of burst.
- dma_gnt  out  1  DMA beat issued this cycle.
- dma_rvalid  out  1  DMA read data valid.
- dma_rdata  out  32  DMA read data.
- dm_cs  out  1  DM chip select.
- dm_web  out  4  DM byte write-enables, active-low.
- dm_a  out  ADDR_W  DM address.
- dm_di  out  32  DM write data.
- dm_do  in  32  DM read data, valid one cycle after a read with dm_cs=1.

## Operation
- Registered state:
  - FSM {IDLE, LOCK}.
  - prio flag (1 = CPU preferred).
  - beat counter, width $clog2(MAX_BURST+1).
  - rd_owner flags rd_cpu, rd_dma.
- Reset: FSM=IDLE, prio=1, counter=0, rd_cpu=rd_dma=0.
- While rst is high, all outputs are 0, except dm_web=4'b1111.
- Grant is combinational from state and requests. At most one grant per cycle; a requester with req=0 is never granted.
- IDLE arbitration:
  - Only one requester: it wins.
  - Both requesting: the prio side wins.
  - On any grant, prio flips to the other side.
- DMA granted in IDLE with dma_last=0 and MAX_BURST>1: FSM→LOCK, counter=1.
- LOCK arbitration:
  - DMA only; cpu_gnt=0 even if CPU is the only requester.
  - Each granted beat increments the counter.
  - FSM→IDLE after a granted beat with dma_last=1, or when counter reaches MAX_BURST, or in any cycle with dma_req=0 (no grant that cycle).
  - prio=1 on every exit from LOCK, so a waiting CPU wins the next cycle.
- Muxing: the granted side drives dm_cs=1, dm_web, dm_a, dm_di. With no grant: dm_cs=0, dm_web=4'b1111, dm_a=0, dm_di=0.
- Read = granted access with web==4'b1111. Next cycle: the matching rvalid=1 and rdata=dm_do.
- rdata is 0 whenever its rvalid=0.
- Write = any web bit 0. Writes never produce rvalid.
- cpu_stall = cpu_req & ~cpu_gnt, combinational.

## Timing
- Request to grant to dm_* issue: same cycle, 0 latency.
- Read data: rvalid exactly one cycle after the granted read. Back-to-back reads give back-to-back rvalid.
- Alternating reads (CPU, DMA, CPU) give rvalids on the matching sides in order, one per cycle.
- DMA burst: at most MAX_BURST consecutive DMA grants, then a CPU grant if cpu_req=1. CPU worst-case wait is MAX_BURST cycles.
- Reset asserted mid-burst or with a read outstanding: FSM=IDLE immediately. No rvalid is produced for the killed read.
- MAX_BURST=1: LOCK is never entered; pure round-robin.
- dma_last=1 on the first beat: no lock.

## Test plan
- Reset, then CPU read addr 0x010 with DM returning 0xDEADBEEF:
  - cycle 0: cpu_gnt=1, dm_cs=1, dm_web=1111, dm_a=0x010.
  - cycle 1: cpu_rvalid=1, cpu_rdata=0xDEADBEEF.
- Both requesting continuously with single beats (dma_last=1):
  - grants alternate CPU, DMA, CPU, DMA…, starting with CPU after reset.
  - cpu_stall=1 exactly on DMA cycles.
- DMA 4-beat burst (dma_last on beat 4), CPU requesting throughout, MAX_BURST=8:
  - dma_gnt for 4 cycles, then cpu_gnt on cycle 5.
  - cpu_stall=1 on cycles 1–4.
- DMA requests 12 beats without dma_last, CPU requesting, MAX_BURST=8:
  - 8 DMA grants, then 1 CPU grant, then DMA resumes.
- CPU SB write cpu_web=1110, wdata=0x000000AB, addr 0x004:
  - dm_web=1110, dm_di=0x000000AB, dm_a=0x004 in the grant cycle.
  - no cpu_rvalid next cycle.
- Assert rst in the cycle after a granted DMA read in LOCK:
  - dma_rvalid stays 0.
  - all grants are 0 during reset.
  - after release, CPU wins the first contention.

Source files
------------

// File: rtl/dm_arbiter.sv
// dm_arbiter: round-robin arbiter between the CPU MEM stage and a DMA engine
// for the single-port data memory, with a bounded DMA burst lock and a
// one-cycle read-data return path to whichever side issued the read.
module dm_arbiter #(
  parameter int ADDR_W    = 14,
  parameter int MAX_BURST = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic [3:0]        cpu_web,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [31:0]       cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [31:0]       cpu_rdata,
  output logic              cpu_stall,
  input  logic              dma_req,
  input  logic [3:0]        dma_web,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [31:0]       dma_wdata,
  input  logic              dma_last,
  output logic              dma_gnt,
  output logic              dma_rvalid,
  output logic [31:0]       dma_rdata,
  output logic              dm_cs,
  output logic [3:0]        dm_web,
  output logic [ADDR_W-1:0] dm_a,
  output logic [31:0]       dm_di,
  input  logic [31:0]       dm_do
);

  localparam int                CNT_W    = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(MAX_BURST);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam bit                BURST_EN = (MAX_BURST > 1);

  typedef enum logic {IDLE, LOCK} state_t;

  state_t           state, state_n;
  logic             prio, prio_n;
  logic [CNT_W-1:0] cnt, cnt_n, cnt_inc;
  logic             rd_cpu, rd_cpu_n;
  logic             rd_dma, rd_dma_n;
  logic             cpu_win, dma_win;

  assign cnt_inc = cnt + CNT_ONE;

  // Decide who owns the DM this cycle; reset blocks every grant, LOCK shuts the CPU out.
  always_comb begin
    cpu_win = 1'b0;
    dma_win = 1'b0;
    if (!rst) begin
      if (state == LOCK) begin
        dma_win = dma_req;
      end else if (cpu_req && dma_req) begin
        cpu_win = prio;
        dma_win = ~prio;
      end else begin
        cpu_win = cpu_req;
        dma_win = dma_req;
      end
    end
  end

  // Next-state: round-robin priority flip, burst lock entry/exit, read ownership tracking.
  always_comb begin
    state_n  = state;
    prio_n   = prio;
    cnt_n    = cnt;
    rd_cpu_n = cpu_win && (cpu_web == 4'b1111);
    rd_dma_n = dma_win && (dma_web == 4'b1111);
    case (state)
      IDLE: begin
        if (cpu_win) begin
          prio_n = 1'b0;
        end
        if (dma_win) begin
          prio_n = 1'b1;
          if (!dma_last && BURST_EN) begin
            state_n = LOCK;
            cnt_n   = CNT_ONE;
          end
        end
      end
      LOCK: begin
        if (dma_win && !dma_last && (cnt_inc != CNT_MAX)) begin
          cnt_n = cnt_inc;
        end else begin
          state_n = IDLE;
          prio_n  = 1'b1;
          cnt_n   = '0;
        end
      end
      default: begin
        state_n = IDLE;
        prio_n  = 1'b1;
        cnt_n   = '0;
      end
    endcase
  end

  // State register; reset drops the lock and forgets any outstanding read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      prio   <= 1'b1;
      cnt    <= '0;
      rd_cpu <= 1'b0;
      rd_dma <= 1'b0;
    end else begin
      state  <= state_n;
      prio   <= prio_n;
      cnt    <= cnt_n;
      rd_cpu <= rd_cpu_n;
      rd_dma <= rd_dma_n;
    end
  end

  // Steer the granted side onto the DM pins; idle pins read as deselected.
  always_comb begin
    dm_cs  = 1'b0;
    dm_web = 4'b1111;
    dm_a   = '0;
    dm_di  = '0;
    if (cpu_win) begin
      dm_cs  = 1'b1;
      dm_web = cpu_web;
      dm_a   = cpu_addr;
      dm_di  = cpu_wdata;
    end else if (dma_win) begin
      dm_cs  = 1'b1;
      dm_web = dma_web;
      dm_a   = dma_addr;
      dm_di  = dma_wdata;
    end
  end

  // Return read data to its owner and keep the data buses quiet otherwise.
  always_comb begin
    cpu_gnt    = cpu_win;
    dma_gnt    = dma_win;
    cpu_stall  = cpu_req && !cpu_win && !rst;
    cpu_rvalid = rd_cpu;
    dma_rvalid = rd_dma;
    cpu_rdata  = rd_cpu ? dm_do : 32'h0;
    dma_rdata  = rd_dma ? dm_do : 32'h0;
  end

endmodule

// File: tb/tb_dm_arbiter.sv
// tb_dm_arbiter: directed bench for dm_arbiter with a behavioural reference
// model checked every cycle plus hand-computed expectations per scenario.
module tb_dm_arbiter;

  localparam int ADDR_W    = 14;
  localparam int MAX_BURST = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              cpu_req, dma_req, dma_last;
  logic [3:0]        cpu_web, dma_web;
  logic [ADDR_W-1:0] cpu_addr, dma_addr;
  logic [31:0]       cpu_wdata, dma_wdata, dm_do;
  logic              cpu_gnt, cpu_rvalid, cpu_stall, dma_gnt, dma_rvalid, dm_cs;
  logic [31:0]       cpu_rdata, dma_rdata, dm_di;
  logic [3:0]        dm_web;
  logic [ADDR_W-1:0] dm_a;

  int checks   = 0;
  int failures = 0;

  dm_arbiter #(.ADDR_W(ADDR_W), .MAX_BURST(MAX_BURST)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_web(cpu_web), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .dma_req(dma_req), .dma_web(dma_web), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_last(dma_last), .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
    .dm_cs(dm_cs), .dm_web(dm_web), .dm_a(dm_a), .dm_di(dm_di), .dm_do(dm_do)
  );

  // Free-running clock, period 10.
  always #5 clk = ~clk;

  // Reference model state: who is preferred, whether DMA holds a burst, how many beats it has had.
  bit m_prefer_cpu;
  bit m_locked;
  int m_beats;
  bit m_rd_cpu, m_rd_dma;

  logic              exp_cpu_gnt, exp_dma_gnt, exp_cs, exp_stall;
  logic [3:0]        exp_web;
  logic [ADDR_W-1:0] exp_a;
  logic [31:0]       exp_di;

  assign exp_cpu_gnt = !rst && cpu_req && !m_locked && (!dma_req || m_prefer_cpu);
  assign exp_dma_gnt = !rst && dma_req && (m_locked || !cpu_req || !m_prefer_cpu);
  assign exp_cs      = exp_cpu_gnt || exp_dma_gnt;
  assign exp_stall   = !rst && cpu_req && !exp_cpu_gnt;
  assign exp_web     = exp_cpu_gnt ? cpu_web   : exp_dma_gnt ? dma_web   : 4'b1111;
  assign exp_a       = exp_cpu_gnt ? cpu_addr  : exp_dma_gnt ? dma_addr  : '0;
  assign exp_di      = exp_cpu_gnt ? cpu_wdata : exp_dma_gnt ? dma_wdata : 32'h0;

  // Advance the reference model from the arbitration rules each rising edge.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_prefer_cpu <= 1'b1;
      m_locked     <= 1'b0;
      m_beats      <= 0;
      m_rd_cpu     <= 1'b0;
      m_rd_dma     <= 1'b0;
    end else begin
      m_rd_cpu <= exp_cpu_gnt && (cpu_web == 4'b1111);
      m_rd_dma <= exp_dma_gnt && (dma_web == 4'b1111);
      if (m_locked) begin
        if (!dma_req || dma_last || (m_beats + 1 >= MAX_BURST)) begin
          m_locked     <= 1'b0;
          m_prefer_cpu <= 1'b1;
          m_beats      <= 0;
        end else begin
          m_beats <= m_beats + 1;
        end
      end else begin
        if (exp_cpu_gnt) m_prefer_cpu <= 1'b0;
        if (exp_dma_gnt) begin
          m_prefer_cpu <= 1'b1;
          if (!dma_last && MAX_BURST > 1) begin
            m_locked <= 1'b1;
            m_beats  <= 1;
          end
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare every DUT output against the model on each falling edge.
  always @(negedge clk) begin
    checkOutput("m_cpu_gnt",    32'(cpu_gnt),    32'(exp_cpu_gnt));
    checkOutput("m_dma_gnt",    32'(dma_gnt),    32'(exp_dma_gnt));
    checkOutput("m_cpu_stall",  32'(cpu_stall),  32'(exp_stall));
    checkOutput("m_dm_cs",      32'(dm_cs),      32'(exp_cs));
    checkOutput("m_dm_web",     32'(dm_web),     32'(exp_web));
    checkOutput("m_dm_a",       32'(dm_a),       32'(exp_a));
    checkOutput("m_dm_di",      dm_di,           exp_di);
    checkOutput("m_cpu_rvalid", 32'(cpu_rvalid), 32'(!rst && m_rd_cpu));
    checkOutput("m_cpu_rdata",  cpu_rdata,       (!rst && m_rd_cpu) ? dm_do : 32'h0);
    checkOutput("m_dma_rvalid", 32'(dma_rvalid), 32'(!rst && m_rd_dma));
    checkOutput("m_dma_rdata",  dma_rdata,       (!rst && m_rd_dma) ? dm_do : 32'h0);
  end

  // Drive one cycle of inputs just after the rising edge, then wait for the sampling edge.
  task automatic applyStimulus(
    input logic c_req, input logic [3:0] c_web, input logic [ADDR_W-1:0] c_addr, input logic [31:0] c_wdata,
    input logic d_req, input logic [3:0] d_web, input logic [ADDR_W-1:0] d_addr, input logic [31:0] d_wdata,
    input logic d_last, input logic [31:0] do_val);
    @(posedge clk);
    #1;
    cpu_req = c_req; cpu_web = c_web; cpu_addr = c_addr; cpu_wdata = c_wdata;
    dma_req = d_req; dma_web = d_web; dma_addr = d_addr; dma_wdata = d_wdata;
    dma_last = d_last; dm_do = do_val;
    @(negedge clk);
  endtask

  task automatic idleCycle(input logic [31:0] do_val);
    applyStimulus(1'b0, 4'hF, '0, 32'h0, 1'b0, 4'hF, '0, 32'h0, 1'b0, do_val);
  endtask

  int beats_done;

  // Directed scenarios in sequence.
  initial begin
    rst = 1'b1;
    cpu_req = 1'b1; cpu_web = 4'hF; cpu_addr = 14'h055; cpu_wdata = 32'h1111_1111;
    dma_req = 1'b1; dma_web = 4'hF; dma_addr = 14'h066; dma_wdata = 32'h2222_2222;
    dma_last = 1'b0; dm_do = 32'hFFFF_FFFF;
    @(negedge clk);
    checkOutput("rst_cpu_gnt",   32'(cpu_gnt),   32'h0);
    checkOutput("rst_dma_gnt",   32'(dma_gnt),   32'h0);
    checkOutput("rst_cpu_stall", 32'(cpu_stall), 32'h0);
    checkOutput("rst_dm_web",    32'(dm_web),    32'hF);
    checkOutput("rst_dm_cs",     32'(dm_cs),     32'h0);
    @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    cpu_req = 1'b0; dma_req = 1'b0;

    // Both sides requesting single beats: alternate starting with CPU.
    for (int k = 0; k < 6; k++) begin
      applyStimulus(1'b1, 4'hF, 14'(16'h0040 + k), 32'h0, 1'b1, 4'hF, 14'(16'h0080 + k), 32'h0,
                    1'b1, 32'hA500_0000 + 32'(k));
      checkOutput($sformatf("alt_cpu_gnt%0d", k),   32'(cpu_gnt),   32'((k % 2) == 0));
      checkOutput($sformatf("alt_dma_gnt%0d", k),   32'(dma_gnt),   32'((k % 2) == 1));
      checkOutput($sformatf("alt_cpu_stall%0d", k), 32'(cpu_stall), 32'((k % 2) == 1));
    end

    // CPU read of 0x010 with DM returning 0xDEADBEEF.
    applyStimulus(1'b1, 4'hF, 14'h010, 32'h0, 1'b0, 4'hF, '0, 32'h0, 1'b0, 32'h0BAD_0000);
    checkOutput("rd_cpu_gnt", 32'(cpu_gnt), 32'h1);
    checkOutput("rd_dm_cs",   32'(dm_cs),   32'h1);
    checkOutput("rd_dm_web",  32'(dm_web),  32'hF);
    checkOutput("rd_dm_a",    32'(dm_a),    32'h010);
    idleCycle(32'hDEAD_BEEF);
    checkOutput("rd_cpu_rvalid", 32'(cpu_rvalid), 32'h1);
    checkOutput("rd_cpu_rdata",  cpu_rdata,       32'hDEAD_BEEF);

    // CPU byte write to 0x004.
    applyStimulus(1'b1, 4'b1110, 14'h004, 32'h0000_00AB, 1'b0, 4'hF, '0, 32'h0, 1'b0, 32'h1234_5678);
    checkOutput("sb_cpu_gnt", 32'(cpu_gnt), 32'h1);
    checkOutput("sb_dm_web",  32'(dm_web),  32'hE);
    checkOutput("sb_dm_di",   dm_di,        32'h0000_00AB);
    checkOutput("sb_dm_a",    32'(dm_a),    32'h004);
    idleCycle(32'h8765_4321);
    checkOutput("sb_cpu_rvalid", 32'(cpu_rvalid), 32'h0);
    checkOutput("sb_cpu_rdata",  cpu_rdata,       32'h0);

    // DMA 4-beat read burst while CPU keeps requesting; CPU last won so DMA goes first.
    for (int k = 1; k <= 5; k++) begin
      applyStimulus(1'b1, 4'hF, 14'h020, 32'h0, (k <= 4), 4'hF, 14'(16'h0300 + k), 32'h0,
                    (k == 4), 32'hC0DE_0000 + 32'(k));
      checkOutput($sformatf("b4_dma_gnt%0d", k),   32'(dma_gnt),   32'(k <= 4));
      checkOutput($sformatf("b4_cpu_gnt%0d", k),   32'(cpu_gnt),   32'(k == 5));
      checkOutput($sformatf("b4_cpu_stall%0d", k), 32'(cpu_stall), 32'(k <= 4));
    end
    idleCycle(32'h0);

    // DMA wants 12 write beats without dma_last; lock caps at MAX_BURST.
    beats_done = 0;
    for (int c = 1; c <= 14; c++) begin
      applyStimulus(1'b1, 4'hF, 14'h030, 32'h0, (beats_done < 12), 4'h0, 14'(16'h0200 + beats_done),
                    32'hBEEF_0000 + 32'(beats_done), 1'b0, 32'h5A5A_0000 + 32'(c));
      if (c <= 8) checkOutput($sformatf("b12_dma_gnt%0d", c), 32'(dma_gnt), 32'h1);
      if (c == 9) checkOutput("b12_cpu_gnt9", 32'(cpu_gnt), 32'h1);
      if (c == 10) checkOutput("b12_dma_gnt10", 32'(dma_gnt), 32'h1);
      if (c == 14) checkOutput("b12_cpu_gnt14", 32'(cpu_gnt), 32'h0);
      if (dma_gnt) beats_done++;
    end
    checkOutput("b12_beats", 32'(beats_done), 32'd12);
    idleCycle(32'h0);

    // Reset in the cycle after a granted DMA read inside LOCK.
    applyStimulus(1'b0, 4'hF, '0, 32'h0, 1'b1, 4'h0, 14'h111, 32'h7777_0000, 1'b0, 32'h0);
    checkOutput("kr_dma_gnt_a", 32'(dma_gnt), 32'h1);
    applyStimulus(1'b0, 4'hF, '0, 32'h0, 1'b1, 4'hF, 14'h112, 32'h0, 1'b0, 32'h0);
    checkOutput("kr_dma_gnt_b", 32'(dma_gnt), 32'h1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    cpu_req = 1'b1; dma_req = 1'b1; dma_web = 4'hF; dm_do = 32'hFACE_FACE;
    @(negedge clk);
    checkOutput("kr_dma_rvalid", 32'(dma_rvalid), 32'h0);
    checkOutput("kr_dma_rdata",  dma_rdata,       32'h0);
    checkOutput("kr_cpu_gnt",    32'(cpu_gnt),    32'h0);
    checkOutput("kr_dma_gnt",    32'(dma_gnt),    32'h0);
    @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("kr_post_cpu_gnt", 32'(cpu_gnt), 32'h1);
    checkOutput("kr_post_dma_gnt", 32'(dma_gnt), 32'h0);
    idleCycle(32'h0);
    idleCycle(32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
